// File: rtl/alu_flag_register.sv
// -----------------------------------------------------------------------------
// alu_flag_register
//
// Status-capture stage that sits after the ALU flag detector. It holds one ALU
// result (carry in the MSB) and its flag vector in a one-entry valid/ready
// buffer. It ORs the flags of every accepted entry into a sticky register and
// counts accepted entries. It also evaluates a condition code against the held
// flags for the branch/display logic that follows.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   producer offers resultado/flags_in
//   in_ready    out  stage can accept this cycle
//   resultado   in   [N:0]  ALU result, bit N = carry-out
//   flags_in    in   [3:0]  {N, V, C, Z}
//   out_valid   out  held entry is valid
//   out_ready   in   consumer takes the held entry
//   result_q    out  [N:0]  held result
//   flags_q     out  [3:0]  held flags, same bit map as flags_in
//   sticky_q    out  [3:0]  OR of the flags of all accepted entries since clear
//   clr_sticky  in   synchronous clear of sticky_q
//   cond        in   [3:0]  condition code (EQ..NV)
//   cond_true   out  condition evaluated on the held flags, 0 when empty
//   op_count    out  [CNT_W-1:0] accepted entries, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_flag_register #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       resultado,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       result_q,
  output logic [3:0]       flags_q,
  output logic [3:0]       sticky_q,
  input  logic             clr_sticky,
  input  logic [3:0]       cond,
  output logic             cond_true,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Flag bit positions inside flags_in / flags_q / sticky_q.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  state_e           state_q, state_d;
  logic [N:0]       result_d;
  logic [3:0]       flags_d;
  logic [3:0]       sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             accept;
  logic             cond_hit;

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here, data included, is reset because the reset values
  // of result_q/flags_q/sticky_q/op_count are visible outputs, not don't-cares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      result_q   <= '0;
      flags_q    <= '0;
      sticky_q   <= '0;
      op_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (in_valid) state_d = FULL;
      // FULL with out_ready and in_valid stays FULL (back-to-back refill).
      FULL:  if (out_ready && !in_valid) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake outputs
  // ---------------------------------------------------------------------------
  // In FULL, space opens in the same cycle the consumer drains the entry, which
  // gives one entry per cycle without a bubble.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      FULL: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  assign accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    result_d   = result_q;
    flags_d    = flags_q;
    sticky_d   = sticky_q;
    op_count_d = op_count_q;

    // The clear is applied before the OR, so a clear during an accept leaves
    // only the new entry's flags.
    if (clr_sticky) sticky_d = '0;

    if (accept) begin
      result_d   = resultado;
      flags_d    = flags_in;
      sticky_d   = sticky_d | flags_in;
      op_count_d = op_count_q + 1'b1;  // wraps naturally at 2^CNT_W
    end
  end

  assign op_count = op_count_q;

  // ---------------------------------------------------------------------------
  // Condition-code evaluation on the held flags
  // ---------------------------------------------------------------------------
  always_comb begin
    logic z, c, v, n;
    z = flags_q[FLAG_Z];
    c = flags_q[FLAG_C];
    v = flags_q[FLAG_V];
    n = flags_q[FLAG_N];

    cond_hit = 1'b0;
    case (cond)
      4'd0:  cond_hit = z;                   // EQ
      4'd1:  cond_hit = !z;                  // NE
      4'd2:  cond_hit = c;                   // CS
      4'd3:  cond_hit = !c;                  // CC
      4'd4:  cond_hit = n;                   // MI
      4'd5:  cond_hit = !n;                  // PL
      4'd6:  cond_hit = v;                   // VS
      4'd7:  cond_hit = !v;                  // VC
      4'd8:  cond_hit = c && !z;             // HI
      4'd9:  cond_hit = !c || z;             // LS
      4'd10: cond_hit = (n == v);            // GE
      4'd11: cond_hit = (n != v);            // LT
      4'd12: cond_hit = !z && (n == v);      // GT
      4'd13: cond_hit = z || (n != v);       // LE
      4'd14: cond_hit = 1'b1;                // AL
      4'd15: cond_hit = 1'b0;                // NV
      default: cond_hit = 1'b0;
    endcase
  end

  // The held flags are stale once drained, so the result is masked when empty.
  assign cond_true = out_valid & cond_hit;

endmodule
